// File: rtl/addsub_seq.sv
// addsub_seq: sequencing front-end for the 4-bit AddSub adder/subtractor.
// It accepts a request on a valid/ready handshake and drives the operands
// into the external adder. After SETTLE cycles it captures the adder
// result into registered outputs, which it holds under an output
// valid/ready handshake. A 4-bit accumulator lets operations chain.
// Optional feature: define ADDSUB_SEQ_SAT_EN to saturate the captured
// sum and the accumulator on signed overflow.
module addsub_seq #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_op,
    input  logic       in_acc,
    input  logic       clr_acc,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_m,
    input  logic [3:0] add_sum,
    input  logic       add_cout,
    input  logic       add_ov,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_sum,
    output logic       out_cout,
    output logic       out_ov,
    output logic [3:0] acc,
    output logic [7:0] done_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [2:0] LP_LAST = 3'(SETTLE - 1);

    state_t     r_state;
    logic [2:0] r_cnt;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [3:0] r_add_a;
    logic [3:0] r_add_b;
    logic       r_add_m;
    logic [3:0] r_out_sum;
    logic       r_out_cout;
    logic       r_out_ov;
    logic [3:0] r_acc;
    logic [7:0] r_done_cnt;
    logic [3:0] w_cap_sum;

    // Value that will be captured into out_sum and acc
    always_comb begin
        w_cap_sum = add_sum;
`ifdef ADDSUB_SEQ_SAT_EN
        if (add_ov) begin
            w_cap_sum = r_add_a[3] ? 4'b1000 : 4'b0111;
        end
`endif
    end

    // Sequencer: accept request, hold operands for SETTLE cycles, capture, hold result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_m     <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_ov    <= 1'b0;
            r_acc       <= '0;
            r_done_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_add_a    <= in_acc ? r_acc : in_a;
                        r_add_b    <= in_b;
                        r_add_m    <= in_op;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (r_cnt == LP_LAST) begin
                        r_out_sum   <= w_cap_sum;
                        r_out_cout  <= add_cout;
                        r_out_ov    <= add_ov;
                        r_acc       <= w_cap_sum;
                        r_done_cnt  <= r_done_cnt + 8'd1;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            // Clear placed last so it overrides a coincident capture
            if (clr_acc) begin
                r_acc <= '0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_m     = r_add_m;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_ov    = r_out_ov;
    assign acc       = r_acc;
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_addsub_seq.sv
// Testbench for addsub_seq: scoreboard + monitor on a SETTLE=1 instance,
// directed latency and reset-abort checks on a SETTLE=4 instance.
module tb_addsub_seq;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       ov;
        logic [3:0] acc;
        logic [7:0] done;
    } exp_t;

    logic clk, rst_n, rst2;
    int   checks = 0;
    int   errors = 0;

    // main instance signals
    logic       in_valid, in_ready, in_op, in_acc, clr_acc, add_m, out_valid, out_ready;
    logic [3:0] in_a, in_b, add_a, add_b, add_sum, out_sum, acc;
    logic       add_cout, add_ov, out_cout, out_ov;
    logic [7:0] done_cnt;

    // SETTLE=4 instance signals
    logic       d4_in_valid, d4_in_ready, d4_in_op, d4_add_m, d4_out_valid, d4_out_ready;
    logic [3:0] d4_in_a, d4_in_b, d4_add_a, d4_add_b, d4_add_sum, d4_out_sum, d4_acc;
    logic       d4_add_cout, d4_add_ov, d4_out_cout, d4_out_ov;
    logic [7:0] d4_done_cnt;

    exp_t       sb[$];
    exp_t       cur;
    logic       have_cur = 1'b0;
    logic       prev_v = 1'b0;
    logic [3:0] m_acc = 4'd0;
    logic [7:0] m_done = 8'd0;

    // Gate-level-style model of the neighbouring AddSub block: A + (B^M) + M
    function automatic logic [5:0] addsub4(input logic [3:0] a, input logic [3:0] b, input logic m);
        logic [3:0] bx;
        logic [4:0] t;
        bx = b ^ {4{m}};
        t  = {1'b0, a} + {1'b0, bx} + {4'b0000, m};
        return {(a[3] == bx[3]) && (t[3] != a[3]), t[4], t[3:0]};
    endfunction

    assign {add_ov, add_cout, add_sum}          = addsub4(add_a, add_b, add_m);
    assign {d4_add_ov, d4_add_cout, d4_add_sum} = addsub4(d4_add_a, d4_add_b, d4_add_m);

    addsub_seq #(.SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .clr_acc(clr_acc),
        .add_a(add_a), .add_b(add_b), .add_m(add_m),
        .add_sum(add_sum), .add_cout(add_cout), .add_ov(add_ov),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ov(out_ov), .acc(acc), .done_cnt(done_cnt)
    );

    addsub_seq #(.SETTLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst2), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .in_a(d4_in_a), .in_b(d4_in_b), .in_op(d4_in_op), .in_acc(1'b0), .clr_acc(1'b0),
        .add_a(d4_add_a), .add_b(d4_add_b), .add_m(d4_add_m),
        .add_sum(d4_add_sum), .add_cout(d4_add_cout), .add_ov(d4_add_ov),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_sum(d4_out_sum),
        .out_cout(d4_out_cout), .out_ov(d4_out_ov), .acc(d4_acc), .done_cnt(d4_done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer arithmetic on unsigned and signed readings of the operands
    function automatic exp_t ref_op(input logic [3:0] a, input logic [3:0] b, input logic op);
        exp_t e;
        int   ua, ub, sa, sbv, u, s;
        ua  = int'(a);
        ub  = int'(b);
        sa  = (ua > 7) ? ua - 16 : ua;
        sbv = (ub > 7) ? ub - 16 : ub;
        if (op) begin
            u = ua - ub;
            s = sa - sbv;
            e.cout = (ua >= ub);
        end else begin
            u = ua + ub;
            s = sa + sbv;
            e.cout = (u > 15);
        end
        e.sum = 4'(u & 15);
        e.ov  = (s > 7) || (s < -8);
`ifdef ADDSUB_SEQ_SAT_EN
        if (e.ov) e.sum = (sa < 0) ? 4'b1000 : 4'b0111;
`endif
        e.acc  = 4'd0;
        e.done = 8'd0;
        return e;
    endfunction

    // Monitor: pop an expectation on each new result, compare while it is presented
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!prev_v) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(1), 32'(0));
                    have_cur = 1'b0;
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (have_cur) begin
                chk("out_sum",  32'(out_sum),  32'(cur.sum));
                chk("out_cout", 32'(out_cout), 32'(cur.cout));
                chk("out_ov",   32'(out_ov),   32'(cur.ov));
                chk("acc",      32'(acc),      32'(cur.acc));
                chk("done_cnt", 32'(done_cnt), 32'(cur.done));
            end
        end
        prev_v = rst_n && out_valid;
    end

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic op, input logic sel,
                         input logic clr_cap, input int unsigned hold, input logic keep_valid);
        exp_t        e;
        int unsigned n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'(1));
        e      = ref_op(sel ? m_acc : a, b, op);
        m_done = m_done + 8'd1;
        m_acc  = clr_cap ? 4'd0 : e.sum;
        e.acc  = m_acc;
        e.done = m_done;
        sb.push_back(e);
        in_a      = sel ? 4'($urandom) : a;
        in_b      = b;
        in_op     = op;
        in_acc    = sel;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        chk("accept_in_ready", 32'(in_ready), 32'(0));
        in_valid = keep_valid;
        clr_acc  = clr_cap;
        @(posedge clk); #1;
        clr_acc = 1'b0;
        chk("latency_out_valid", 32'(out_valid), 32'(1));
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_in_ready", 32'(in_ready), 32'(0));
            chk("hold_out_valid", 32'(out_valid), 32'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 32'(in_ready), 32'(1));
        chk("release_out_valid", 32'(out_valid), 32'(0));
        out_ready = 1'b0;
    endtask

    task automatic chk_d4_reset(input string name);
        chk(name, 32'({d4_in_ready, d4_out_valid, d4_add_a, d4_add_b, d4_add_m, d4_out_sum,
                      d4_out_cout, d4_out_ov, d4_acc, d4_done_cnt}), 32'({1'b1, 28'd0}));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e4;
        rst_n = 1'b0; rst2 = 1'b0;
        in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_acc = 0; clr_acc = 0; out_ready = 0;
        d4_in_valid = 0; d4_in_a = 0; d4_in_b = 0; d4_in_op = 0; d4_out_ready = 1;
        #12;
        chk("reset_main", 32'({in_ready, out_valid, add_a, add_b, add_m, out_sum,
                              out_cout, out_ov, acc, done_cnt}), 32'({1'b1, 28'd0}));
        chk_d4_reset("reset_d4");
        rst_n = 1'b1; rst2 = 1'b1;
        @(posedge clk); #1;

        do_op(4'b0101, 4'b1010, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        do_op(4'b1001, 4'b0101, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        do_op(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        do_op(4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        do_op(4'b0011, 4'b0100, 1'b0, 1'b0, 1'b0, 5, 1'b1);
        do_op(4'b1010, 4'b1010, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        for (int k = 0; k < 250; k++) begin
            do_op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 15) == 0), $urandom_range(0, 2), 1'($urandom));
        end
        chk("done_cnt_wrap", 32'(done_cnt), 32'(0));
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));

        // SETTLE=4: latency of a full operation
        e4 = ref_op(4'd2, 4'd3, 1'b0);
        d4_in_a = 4'd2; d4_in_b = 4'd3; d4_in_op = 1'b0; d4_in_valid = 1'b1;
        @(posedge clk); #1;
        d4_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("d4_not_yet_valid", 32'(d4_out_valid), 32'(0));
        @(posedge clk); #1;
        chk("d4_valid_after_settle", 32'(d4_out_valid), 32'(1));
        chk("d4_out_sum", 32'(d4_out_sum), 32'(e4.sum));
        chk("d4_done_cnt", 32'(d4_done_cnt), 32'(1));
        @(posedge clk); #1;
        chk("d4_release_in_ready", 32'(d4_in_ready), 32'(1));

        // SETTLE=4: reset asserted during DRIVE aborts the operation
        d4_in_a = 4'd7; d4_in_b = 4'd7; d4_in_valid = 1'b1;
        @(posedge clk); #1;
        d4_in_valid = 1'b0;
        @(posedge clk); #3;
        rst2 = 1'b0;
        #1;
        chk_d4_reset("d4_async_reset");
        #2;
        rst2 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("d4_no_valid_after_abort", 32'(d4_out_valid), 32'(0));
        end
        chk("d4_done_after_abort", 32'(d4_done_cnt), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
